seq1010_transmitter: RTL and testbench

//  Frame transmitter for the 1010 serial link: accepts a parallel word, emits a 1010

---
 rtl/seq1010_pkg.sv | 24 ++
 rtl/seq1010_transmitter_if.sv | 33 +++
 rtl/piso_shift_reg.sv | 30 +++
 rtl/seq1010_transmitter.sv | 135 +++++++++++++
 tb/tb_seq1010_transmitter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq1010_pkg.sv
// Shared definitions for the 1010 serial link transmitter and its receive-side bench.
// Holds the frame FSM state encoding, the default preamble and the default widths.
// Counter sizing helper keeps the transmitter and any peer logic in agreement.
package seq1010_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } tx_state_e;

  localparam int         DEF_DATA_W    = 8;
  localparam int         DEF_PRE_W     = 4;
  localparam logic [3:0] PREAMBLE_1010 = 4'b1010;

  // Bits needed to count down from the longer of preamble and payload to zero.
  function automatic int cnt_width(input int pre_w, input int data_w);
    int m;
    m = (pre_w > data_w) ? pre_w : data_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq1010_transmitter_if.sv
// Parallel-load / serial-out link between a word source and the 1010 transmitter.
// master side offers words with load and watches the serial line; slave side is the transmitter.
// ready is the only flow control: a word is taken on a clock edge with load & ready.
interface seq1010_transmitter_if #(
  parameter int DATA_W = 8
) ();

  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              x;
  logic              x_valid;
  logic              done;

  modport master (
    output load,
    output data_in,
    input  ready,
    input  x,
    input  x_valid,
    input  done
  );

  modport slave (
    input  load,
    input  data_in,
    output ready,
    output x,
    output x_valid,
    output done
  );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register for the frame payload, MSB presented first.
// Latency: word visible at msb the cycle after the loading edge; one shift per enabled edge.
// No backpressure: the owning FSM decides when to load and when to shift.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  output logic         msb
);

  logic [W-1:0] sr;

  // Load has priority over shift; zeros fill from the LSB so a single-bit register also works.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/seq1010_transmitter.sv
// Frame transmitter: preamble MSB-first, then the payload MSB-first, then one guard cycle.
// Latency: first preamble bit on x the cycle after the accepting edge; frame = PRE_W+DATA_W+1 cycles.
// Backpressure: ready is high only in IDLE; load while busy is dropped, nothing is buffered.
module seq1010_transmitter
  import seq1010_pkg::*;
#(
  parameter int               DATA_W   = DEF_DATA_W,
  parameter int               PRE_W    = DEF_PRE_W,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(PREAMBLE_1010)
) (
  input logic                 clk,
  input logic                 reset,
  seq1010_transmitter_if.slave bus
);

  localparam int CW = cnt_width(PRE_W, DATA_W);

  tx_state_e        state;
  tx_state_e        state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic             x_q;
  logic             x_nx;
  logic             vld_q;
  logic             vld_nx;
  logic             done_q;
  logic             done_nx;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_msb;
  logic [PRE_W-1:0] pre_sh;

  piso_shift_reg #(
    .W (DATA_W)
  ) u_payload (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .din   (bus.data_in),
    .shift (sr_shift),
    .msb   (sr_msb)
  );

  // State, bit counter and all serial-side outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      x_q    <= 1'b0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      x_q    <= x_nx;
      vld_q  <= vld_nx;
      done_q <= done_nx;
    end
  end

  // Next-state and next-output decode; cnt holds the index of the bit currently on x.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    x_nx     = x_q;
    vld_nx   = vld_q;
    done_nx  = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    // Preamble bit that follows the one now on the line; only consumed while cnt != 0.
    pre_sh   = PREAMBLE >> (cnt - CW'(1));

    unique case (state)
      IDLE: begin
        x_nx   = 1'b0;
        vld_nx = 1'b0;
        cnt_nx = '0;
        if (bus.load) begin
          sr_load  = 1'b1;
          x_nx     = PREAMBLE[PRE_W-1];
          vld_nx   = 1'b1;
          cnt_nx   = CW'(PRE_W - 1);
          state_nx = PRE;
        end
      end

      PRE: begin
        if (cnt != '0) begin
          x_nx   = pre_sh[0];
          cnt_nx = cnt - CW'(1);
        end else begin
          // Last preamble bit is on the line: hand over to the payload MSB.
          x_nx     = sr_msb;
          sr_shift = 1'b1;
          cnt_nx   = CW'(DATA_W - 1);
          state_nx = DATA;
        end
      end

      DATA: begin
        if (cnt != '0) begin
          x_nx     = sr_msb;
          sr_shift = 1'b1;
          cnt_nx   = cnt - CW'(1);
        end else begin
          // Payload LSB is on the line: drop to the guard cycle and flag completion.
          x_nx     = 1'b0;
          vld_nx   = 1'b0;
          done_nx  = 1'b1;
          state_nx = GUARD;
        end
      end

      GUARD: begin
        x_nx     = 1'b0;
        vld_nx   = 1'b0;
        cnt_nx   = '0;
        state_nx = IDLE;
      end

      default: begin
        x_nx     = 1'b0;
        vld_nx   = 1'b0;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.ready   = (state == IDLE);
  assign bus.x       = x_q;
  assign bus.x_valid = vld_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq1010_transmitter.sv
// Scoreboard bench for seq1010_transmitter: 8-bit and 1-bit payload instances side by side.
// Expected per-cycle line contents are queued on acceptance and popped by negedge monitors.
// Directed frames plus randomized load/data traffic, including an asynchronous mid-run reset.
module tb_seq1010_transmitter;
  import seq1010_pkg::*;

  localparam int         DW  = 8;
  localparam int         DW1 = 1;
  localparam int         PW  = 4;
  localparam logic [3:0] PRE = 4'b1010;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq1010_transmitter_if #(.DATA_W(DW))  bus0 ();
  seq1010_transmitter_if #(.DATA_W(DW1)) bus1 ();

  seq1010_transmitter #(.DATA_W(DW), .PRE_W(PW), .PREAMBLE(PRE)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  seq1010_transmitter #(.DATA_W(DW1), .PRE_W(PW), .PREAMBLE(PRE)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame = preamble bits, payload bits, guard ----------------
  logic [2:0] q0[$];   // {x, x_valid, done} per output cycle
  logic [2:0] q1[$];
  int busy0 = 0, busy1 = 0;
  int acc0 = 0, acc1 = 0;

  // Instance 0: a word is taken when the line is free and load is high; then busy for the frame.
  always @(posedge clk or posedge reset) begin
    logic [DW-1:0] d;
    if (reset) begin
      q0.delete();
      busy0 = 0;
    end else if (busy0 == 0) begin
      if (bus0.load) begin
        d = bus0.data_in;
        for (int i = PW - 1; i >= 0; i--) q0.push_back({PRE[i], 2'b10});
        for (int i = DW - 1; i >= 0; i--) q0.push_back({d[i], 2'b10});
        q0.push_back(3'b001);
        busy0 = PW + DW + 1;
        acc0++;
      end
    end else begin
      busy0--;
    end
  end

  // Instance 1: same frame rule with a single payload bit.
  always @(posedge clk or posedge reset) begin
    logic [DW1-1:0] d;
    if (reset) begin
      q1.delete();
      busy1 = 0;
    end else if (busy1 == 0) begin
      if (bus1.load) begin
        d = bus1.data_in;
        for (int i = PW - 1; i >= 0; i--) q1.push_back({PRE[i], 2'b10});
        for (int i = DW1 - 1; i >= 0; i--) q1.push_back({d[i], 2'b10});
        q1.push_back(3'b001);
        busy1 = PW + DW1 + 1;
        acc1++;
      end
    end else begin
      busy1--;
    end
  end

  // ---------------- monitors ----------------
  logic [31:0] cap0 = '0, cap1 = '0;
  logic [3:0]  hist0 = '0;
  int done_cnt0 = 0, done_cnt1 = 0;
  int z_cnt0 = 0, z_pos0 = 0, vld0 = 0, cyc0 = 0;
  int rlow0 = 0, last_rlow0 = 0, rlow1 = 0, last_rlow1 = 0;
  int starts0[$];

  // Instance 0: compare the line against the queued frame, plus capture/detector bookkeeping.
  always @(negedge clk) begin
    logic [2:0] e;
    e = 3'b000;
    if (!reset && q0.size() > 0) e = q0.pop_front();
    check("dut0 line", {bus0.x, bus0.x_valid, bus0.done}, e);
    check("dut0 ready", bus0.ready, busy0 == 0);
    cyc0++;
    if (bus0.x_valid) begin
      if (vld0 == 0) starts0.push_back(cyc0);
      vld0++;
      cap0 = {cap0[30:0], bus0.x};
    end else begin
      vld0 = 0;
    end
    if (bus0.done) done_cnt0++;
    hist0 = {hist0[2:0], bus0.x};
    if (hist0 == 4'b1010) begin
      z_cnt0++;
      z_pos0 = vld0;
    end
    if (!bus0.ready) rlow0++;
    else begin
      if (rlow0 != 0) last_rlow0 = rlow0;
      rlow0 = 0;
    end
  end

  // Instance 1: same scoreboard comparison for the single-bit payload.
  always @(negedge clk) begin
    logic [2:0] e;
    e = 3'b000;
    if (!reset && q1.size() > 0) e = q1.pop_front();
    check("dut1 line", {bus1.x, bus1.x_valid, bus1.done}, e);
    check("dut1 ready", bus1.ready, busy1 == 0);
    if (bus1.x_valid) cap1 = {cap1[30:0], bus1.x};
    if (bus1.done) done_cnt1++;
    if (!bus1.ready) rlow1++;
    else begin
      if (rlow1 != 0) last_rlow1 = rlow1;
      rlow1 = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int cur(input int which);
    case (which)
      0:       return acc0;
      1:       return done_cnt0;
      2:       return done_cnt1;
      default: return 0;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int target, input int maxc);
    int i = 0;
    while (cur(which) < target && i < maxc) begin
      @(negedge clk); #1;
      i++;
    end
    check(name, cur(which) >= target, 1);
  endtask

  task automatic send0(input logic [DW-1:0] d);
    @(negedge clk); #1;
    bus0.load    = 1'b1;
    bus0.data_in = d;
    @(negedge clk); #1;
    bus0.load    = 1'b0;
    bus0.data_in = DW'($urandom);
  endtask

  task automatic check_idle(input string name);
    check({name, " dut0"}, {bus0.x, bus0.x_valid, bus0.done, bus0.ready}, 4'b0001);
    check({name, " dut1"}, {bus1.x, bus1.x_valid, bus1.done, bus1.ready}, 4'b0001);
  endtask

  // Hard stop if something stalls beyond every bounded wait.
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int a, dc, zb;
    bus0.load = 1'b0; bus0.data_in = '0;
    bus1.load = 1'b0; bus1.data_in = '0;

    // Power-on reset, outputs checked before any clock edge.
    #1 reset = 1'b1;
    #1 check_idle("reset state");
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Single frame 8'hA5: 1010_10100101, one-cycle done, ready back the cycle after.
    cap0 = '0;
    dc   = done_cnt0;
    send0(8'hA5);
    wait_cnt("a5 done seen", 1, dc + 1, 20);
    check("a5 bits", cap0, 32'h0000_0AA5);
    check("a5 done now", bus0.done, 1'b1);
    @(negedge clk); #1;
    check("a5 done one cycle", bus0.done, 1'b0);
    check("a5 ready after guard", bus0.ready, 1'b1);
    check("a5 ready low cycles", last_rlow0, PW + DW + 1);

    // Payload 8'h00 on an idle line: exactly one 1010 match, at the 4th preamble bit.
    repeat (3) @(negedge clk);
    #1;
    zb = z_cnt0;
    dc = done_cnt0;
    send0(8'h00);
    wait_cnt("00 done seen", 1, dc + 1, 20);
    repeat (3) @(negedge clk);
    #1;
    check("00 detector hits", z_cnt0 - zb, 1);
    check("00 detector position", z_pos0, PW);

    // load held high: FF then 0F back-to-back, load toggled inside frame 1.
    cap0 = '0;
    starts0.delete();
    a  = acc0;
    dc = done_cnt0;
    @(negedge clk); #1;
    bus0.load    = 1'b1;
    bus0.data_in = 8'hFF;
    wait_cnt("b2b first accept", 0, a + 1, 5);
    bus0.data_in = 8'h0F;
    repeat (3) begin
      @(negedge clk); #1;
      bus0.load = ~bus0.load;
    end
    @(negedge clk); #1;
    bus0.load = 1'b1;
    wait_cnt("b2b second accept", 0, a + 2, 20);
    bus0.load = 1'b0;
    wait_cnt("b2b both done", 1, dc + 2, 40);
    check("b2b bits", cap0, 32'h00AF_FA0F);
    check("b2b frame count", starts0.size(), 2);
    check("b2b period", (starts0.size() >= 2) ? (starts0[1] - starts0[0]) : 0, PW + DW + 2);

    // Reset during payload bit 3 of 8'hC3: immediate idle, no done, then a clean frame.
    repeat (2) @(negedge clk);
    #1;
    dc = done_cnt0;
    send0(8'hC3);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_idle("mid-frame reset");
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    check("aborted frame no done", done_cnt0 - dc, 0);
    cap0 = '0;
    send0(8'h3C);
    wait_cnt("post-reset done", 1, dc + 1, 20);
    check("post-reset bits", cap0, 32'h0000_0A3C);

    // Single-bit payload instance: 1010_1, guard, ready low 6 cycles.
    cap1 = '0;
    dc   = done_cnt1;
    @(negedge clk); #1;
    bus1.load    = 1'b1;
    bus1.data_in = 1'b1;
    @(negedge clk); #1;
    bus1.load = 1'b0;
    wait_cnt("dw1 done seen", 2, dc + 1, 20);
    check("dw1 bits", cap1, 32'h0000_0015);
    repeat (2) @(negedge clk);
    #1;
    check("dw1 ready low cycles", last_rlow1, PW + DW1 + 1);

    // Random traffic on both instances with one asynchronous reset pulse in the middle.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk); #1;
      bus0.load    = ($urandom_range(0, 3) == 0);
      bus0.data_in = DW'($urandom);
      bus1.load    = ($urandom_range(0, 2) == 0);
      bus1.data_in = DW1'($urandom);
      if (n == 300) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    bus0.load = 1'b0;
    bus1.load = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("dut0 scoreboard drained", q0.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);
    check("random frames accepted", acc0 > 20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
